// File: rtl/pps_mem_arbiter_if.sv
// rtl/pps_mem_arbiter_if.sv - IF/MEM requester and SRAM signal bundle for pps_mem_arbiter
interface pps_mem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_inst;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_bwe;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;
  logic              stall;
  logic              sram_ce;
  logic              sram_oe;
  logic [3:0]        sram_bwe;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_bwe, dm_addr, dm_wdata, sram_rdata,
    input  if_inst, if_ack, dm_rdata, dm_ack, stall,
    input  sram_ce, sram_oe, sram_bwe, sram_addr, sram_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_bwe, dm_addr, dm_wdata, sram_rdata,
    output if_inst, if_ack, dm_rdata, dm_ack, stall,
    output sram_ce, sram_oe, sram_bwe, sram_addr, sram_wdata
  );
endinterface

// File: rtl/pps_mem_arbiter.sv
// rtl/pps_mem_arbiter.sv - round-robin IF/MEM arbiter for one single-ported synchronous SRAM
// Optional performance counters enabled by defining PPS_MEM_ARB_PERF_EN.
module pps_mem_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pps_mem_arbiter_if.slave     bus
`ifdef PPS_MEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_conflict_cnt
`endif
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("pps_mem_arbiter: WAIT_STATES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST, S_DONE} state_t;
  typedef enum logic {G_INST, G_DATA} grant_t;

  state_t            r_state;
  state_t            w_state_nxt;
  grant_t            r_last_grant;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_bwe;
  logic              r_we;
  logic [31:0]       r_if_inst;
  logic [31:0]       r_dm_rdata;

  logic              w_grant_data;
  logic              w_grant_inst;
  logic              w_capture;
  logic              w_sram_ce;
  logic              w_sram_oe;
  logic [3:0]        w_sram_bwe;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [31:0]       w_sram_wdata;
  logic              w_if_ack;
  logic              w_dm_ack;
  logic              w_stall;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    w_capture    = 1'b0;
    w_sram_ce    = 1'b0;
    w_sram_oe    = 1'b0;
    w_sram_bwe   = 4'b0000;
    w_sram_addr  = '0;
    w_sram_wdata = 32'h0;
    w_if_ack     = 1'b0;
    w_dm_ack     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // DATA yields to INST only when DATA held the previous grant
        if (bus.dm_req && (!bus.if_req || r_last_grant == G_INST)) begin
          w_grant_data = 1'b1;
          w_state_nxt  = S_DATA;
        end else if (bus.if_req) begin
          w_grant_inst = 1'b1;
          w_state_nxt  = S_INST;
        end
      end
      S_DATA, S_INST: begin
        w_sram_ce   = 1'b1;
        w_sram_addr = r_addr;
        if (r_we) begin
          w_sram_bwe   = r_bwe;
          w_sram_wdata = r_wdata;
        end else begin
          w_sram_oe = 1'b1;
        end
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_if_ack    = ~rst & (r_last_grant == G_INST);
        w_dm_ack    = ~rst & (r_last_grant == G_DATA);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall = ~rst & ((bus.if_req & ~w_if_ack) | (bus.dm_req & ~w_dm_ack));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= G_INST;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= 32'h0;
      r_bwe        <= 4'b0000;
      r_we         <= 1'b0;
      r_if_inst    <= 32'h0;
      r_dm_rdata   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_data) begin
        r_last_grant <= G_DATA;
        r_addr       <= bus.dm_addr;
        r_wdata      <= bus.dm_wdata;
        r_bwe        <= bus.dm_bwe;
        r_we         <= bus.dm_we;
        r_cnt        <= WS_LOAD;
      end else if (w_grant_inst) begin
        r_last_grant <= G_INST;
        r_addr       <= bus.if_addr;
        r_wdata      <= 32'h0;
        r_bwe        <= 4'b0000;
        r_we         <= 1'b0;
        r_cnt        <= WS_LOAD;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture && r_state == S_INST) begin
        r_if_inst <= bus.sram_rdata;
      end
      if (w_capture && r_state == S_DATA && !r_we) begin
        r_dm_rdata <= bus.sram_rdata;
      end
    end
  end

`ifdef PPS_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt    <= 32'h0;
      perf_conflict_cnt <= 32'h0;
    end else begin
      if (w_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (r_state == S_IDLE && bus.if_req && bus.dm_req) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

  assign bus.if_inst    = r_if_inst;
  assign bus.dm_rdata   = r_dm_rdata;
  assign bus.if_ack     = w_if_ack;
  assign bus.dm_ack     = w_dm_ack;
  assign bus.stall      = w_stall;
  assign bus.sram_ce    = w_sram_ce;
  assign bus.sram_oe    = w_sram_oe;
  assign bus.sram_bwe   = w_sram_bwe;
  assign bus.sram_addr  = w_sram_addr;
  assign bus.sram_wdata = w_sram_wdata;

endmodule
